// File: rtl/median_window_feeder.sv
// Three-tap sample window feeding an external 3-input median stage.
// Registers the returned median one cycle after each window update and flushes the window on idle timeout.
module median_window_feeder #(
  parameter int WIDTH          = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] tap0,
  output logic [WIDTH-1:0] tap1,
  output logic [WIDTH-1:0] tap2,
  input  logic [WIDTH-1:0] median_in,
  output logic             window_valid,
  output logic [WIDTH-1:0] filtered_out,
  output logic             filtered_valid,
  output logic             stale,
  output logic [1:0]       fill_level
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } fill_state_e;

  fill_state_e      state_q, state_d, base_state_s;
  logic [WIDTH-1:0] tap0_q, tap0_d, tap1_q, tap1_d, tap2_q, tap2_d;
  logic [WIDTH-1:0] base_tap0_s, base_tap1_s;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic             pending_q, pending_d;
  logic             fvalid_q, fvalid_d;
  logic             stale_q, stale_d;
  logic             wvalid_q, wvalid_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             timeout_s;
  logic             clear_s;

  // Next-state logic: a flush (external or timeout) is applied first, then any accepted sample shifts in.
  always_comb begin
    state_d      = state_q;
    tap0_d       = tap0_q;
    tap1_d       = tap1_q;
    tap2_d       = tap2_q;
    pending_d    = 1'b0;
    idle_d       = idle_q;
    filt_d       = filt_q;
    fvalid_d     = 1'b0;
    stale_d      = 1'b0;
    wvalid_d     = 1'b0;
    base_state_s = state_q;
    base_tap0_s  = tap0_q;
    base_tap1_s  = tap1_q;

    // A sample arriving on the timeout cycle wins over the timeout.
    timeout_s = (state_q != EMPTY) && (idle_q == CNT_LAST) && !sample_valid;
    clear_s   = flush || timeout_s;

    if (clear_s) begin
      base_state_s = EMPTY;
      base_tap0_s  = {WIDTH{1'b0}};
      base_tap1_s  = {WIDTH{1'b0}};
    end else begin
      base_state_s = state_q;
      base_tap0_s  = tap0_q;
      base_tap1_s  = tap1_q;
    end

    if (sample_valid) begin
      tap0_d = sample_in;
      tap1_d = base_tap0_s;
      tap2_d = base_tap1_s;
      idle_d = {CNT_W{1'b0}};
      case (base_state_s)
        EMPTY:   state_d = ONE;
        ONE:     state_d = TWO;
        default: state_d = FULL;
      endcase
      pending_d = (base_state_s == TWO) || (base_state_s == FULL);
    end else begin
      state_d   = base_state_s;
      tap0_d    = base_tap0_s;
      tap1_d    = base_tap1_s;
      tap2_d    = clear_s ? {WIDTH{1'b0}} : tap2_q;
      pending_d = 1'b0;
      if (clear_s || (base_state_s == EMPTY)) begin
        idle_d = {CNT_W{1'b0}};
      end else begin
        idle_d = idle_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end

    // A flush discards a pending median capture; filtered_out keeps its old value.
    if (pending_q && !clear_s) begin
      fvalid_d = 1'b1;
      filt_d   = median_in;
    end else begin
      fvalid_d = 1'b0;
      filt_d   = filt_q;
    end

    stale_d  = timeout_s && !flush;
    wvalid_d = (state_d == FULL);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      tap0_q    <= {WIDTH{1'b0}};
      tap1_q    <= {WIDTH{1'b0}};
      tap2_q    <= {WIDTH{1'b0}};
      pending_q <= 1'b0;
      idle_q    <= {CNT_W{1'b0}};
      filt_q    <= {WIDTH{1'b0}};
      fvalid_q  <= 1'b0;
      stale_q   <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap0_q    <= tap0_d;
      tap1_q    <= tap1_d;
      tap2_q    <= tap2_d;
      pending_q <= pending_d;
      idle_q    <= idle_d;
      filt_q    <= filt_d;
      fvalid_q  <= fvalid_d;
      stale_q   <= stale_d;
      wvalid_q  <= wvalid_d;
    end
  end

  assign tap0           = tap0_q;
  assign tap1           = tap1_q;
  assign tap2           = tap2_q;
  assign window_valid   = wvalid_q;
  assign filtered_out   = filt_q;
  assign filtered_valid = fvalid_q;
  assign stale          = stale_q;
  assign fill_level     = state_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder with a behavioural median stage and a queue of expected filtered results.
module tb_median_window_feeder;
  localparam int W  = 20;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] sample_in;
  logic         sample_valid;
  logic         flush;
  logic [W-1:0] tap0, tap1, tap2;
  logic [W-1:0] median_in;
  logic         window_valid;
  logic [W-1:0] filtered_out;
  logic         filtered_valid;
  logic         stale;
  logic [1:0]   fill_level;

  int           total = 0;
  int           bad   = 0;
  int           fv_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m0, m1, m2;
  int           mcnt;

  median_window_feeder #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .flush(flush), .tap0(tap0), .tap1(tap1), .tap2(tap2), .median_in(median_in),
    .window_valid(window_valid), .filtered_out(filtered_out),
    .filtered_valid(filtered_valid), .stale(stale), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] med3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
    else if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
    else return c;
  endfunction

  always_comb median_in = med3(tap0, tap1, tap2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance one edge and score any filtered_valid pulse against the queue.
  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (filtered_valid === 1'b1) begin
      fv_cnt++;
      if (exp_q.size() == 0) begin
        chk("fv_spurious", {31'd0, filtered_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("filtered_out", {12'd0, filtered_out}, {12'd0, e});
      end
    end
  endtask

  task automatic model_clear();
    m0 = '0; m1 = '0; m2 = '0; mcnt = 0;
  endtask

  task automatic send(input logic [W-1:0] v, input logic fl);
    sample_in = v; sample_valid = 1'b1; flush = fl;
    tick();
    sample_valid = 1'b0; flush = 1'b0;
    if (fl) model_clear();
    m2 = m1; m1 = m0; m0 = v;
    if (mcnt < 3) mcnt++;
    if (mcnt == 3) exp_q.push_back(med3(m0, m1, m2));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tap0"}, {12'd0, tap0}, 32'd0);
    chk({tag, "_tap1"}, {12'd0, tap1}, 32'd0);
    chk({tag, "_tap2"}, {12'd0, tap2}, 32'd0);
    chk({tag, "_fout"}, {12'd0, filtered_out}, 32'd0);
    chk({tag, "_fv"}, {31'd0, filtered_valid}, 32'd0);
    chk({tag, "_stale"}, {31'd0, stale}, 32'd0);
    chk({tag, "_wv"}, {31'd0, window_valid}, 32'd0);
    chk({tag, "_lvl"}, {30'd0, fill_level}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; sample_in = '0; sample_valid = 1'b0; flush = 1'b0;
    model_clear();
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset");
    tick(); tick();
    reset_n = 1'b1;

    // Fill
    send(20'd100, 1'b0);
    chk("fill1_lvl", {30'd0, fill_level}, 32'd1);
    chk("fill1_tap0", {12'd0, tap0}, 32'd100);
    chk("fill1_wv", {31'd0, window_valid}, 32'd0);
    send(20'd300, 1'b0);
    chk("fill2_lvl", {30'd0, fill_level}, 32'd2);
    chk("fill2_wv", {31'd0, window_valid}, 32'd0);
    send(20'd200, 1'b0);
    chk("fill3_lvl", {30'd0, fill_level}, 32'd3);
    chk("fill3_wv", {31'd0, window_valid}, 32'd1);
    chk("fill3_tap0", {12'd0, tap0}, 32'd200);
    chk("fill3_tap1", {12'd0, tap1}, 32'd300);
    chk("fill3_tap2", {12'd0, tap2}, 32'd100);
    chk("fill3_fv", {31'd0, filtered_valid}, 32'd0);

    // Streaming: fourth sample right behind the third
    send(20'd50, 1'b0);
    chk("str_fv1", {31'd0, filtered_valid}, 32'd1);
    chk("str_fout1", {12'd0, filtered_out}, 32'd200);
    chk("str_tap0", {12'd0, tap0}, 32'd50);
    chk("str_tap1", {12'd0, tap1}, 32'd200);
    chk("str_tap2", {12'd0, tap2}, 32'd300);
    tick();
    chk("str_fv2", {31'd0, filtered_valid}, 32'd1);
    chk("str_fout2", {12'd0, filtered_out}, 32'd200);
    tick();
    chk("str_fv3", {31'd0, filtered_valid}, 32'd0);
    chk("str_cnt", fv_cnt, 32'd2);

    // Flush together with a sample
    send(20'd7, 1'b1);
    chk("fc_lvl", {30'd0, fill_level}, 32'd1);
    chk("fc_tap0", {12'd0, tap0}, 32'd7);
    chk("fc_tap1", {12'd0, tap1}, 32'd0);
    chk("fc_tap2", {12'd0, tap2}, 32'd0);
    chk("fc_wv", {31'd0, window_valid}, 32'd0);
    chk("fc_fout", {12'd0, filtered_out}, 32'd200);
    tick();
    chk("fc_fv", {31'd0, filtered_valid}, 32'd0);

    // Timeout from state TWO
    send(20'd11, 1'b0);
    chk("to_lvl", {30'd0, fill_level}, 32'd2);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk("to_early_stale", {31'd0, stale}, 32'd0);
    end
    chk("to_early_lvl", {30'd0, fill_level}, 32'd2);
    tick();
    chk("to_stale", {31'd1 & 31'd0, stale}, 32'd1);
    chk("to_lvl0", {30'd0, fill_level}, 32'd0);
    chk("to_tap0", {12'd0, tap0}, 32'd0);
    chk("to_tap1", {12'd0, tap1}, 32'd0);
    model_clear();
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("to_after_stale", {31'd0, stale}, 32'd0);
    end

    // Sample on the timeout cycle wins
    send(20'd21, 1'b0);
    send(20'd22, 1'b0);
    for (int k = 1; k < TO; k++) tick();
    send(20'd23, 1'b0);
    chk("race_stale", {31'd0, stale}, 32'd0);
    chk("race_lvl", {30'd0, fill_level}, 32'd3);
    chk("race_wv", {31'd0, window_valid}, 32'd1);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk("race_idle_stale", {31'd0, stale}, 32'd0);
    end
    chk("race_idle_lvl", {30'd0, fill_level}, 32'd3);
    tick();
    chk("race_to_stale", {31'd0, stale}, 32'd1);
    chk("race_to_lvl", {30'd0, fill_level}, 32'd0);
    model_clear();

    // Reset between third sample and its filtered pulse
    send(20'd31, 1'b0);
    send(20'd32, 1'b0);
    send(20'd33, 1'b0);
    reset_n = 1'b0;
    #1 chk_all_zero("midreset");
    exp_q.delete();
    model_clear();
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("rst_fv_cnt", fv_cnt, 32'd3);
    chk("rst_fout", {12'd0, filtered_out}, 32'd0);
    send(20'd5, 1'b0);
    chk("post_lvl", {30'd0, fill_level}, 32'd1);
    chk("post_tap0", {12'd0, tap0}, 32'd5);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/median_window_feeder.md
MEDIAN_WINDOW_FEEDER -- requirements
Module: median_window_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, giving the sample width in bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the idle cycles without a sample before the window is declared stale.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 sample_in  input  WIDTH  new distance sample.
REQ-007 sample_valid  input  1  one-cycle strobe; sample_in is accepted on the rising edge where this is high.
REQ-008 flush  input  1  synchronous request to empty the window.
REQ-009 tap0, tap1, tap2  output  WIDTH each  newest, middle and oldest stored samples; these drive the data1/data2/data3 inputs of the downstream 3-input median stage.
REQ-010 median_in  input  WIDTH  combinational median returned from the median stage.
REQ-011 window_valid  output  1  high while three samples are held.
REQ-012 filtered_out  output  WIDTH  registered median result.
REQ-013 filtered_valid  output  1  one-cycle strobe when filtered_out updates.
REQ-014 stale  output  1  one-cycle strobe when a timeout flush occurs.
REQ-015 fill_level  output  2  number of stored samples, 0 to 3.

Function
REQ-016 On an accepted sample, the window SHALL shift: tap2<=tap1, tap1<=tap0, tap0<=sample_in.
REQ-017 The fill state machine SHALL have states EMPTY(0), ONE(1), TWO(2) and FULL(3), and fill_level SHALL equal the state.
REQ-018 An accepted sample SHALL advance the state by one, and FULL SHALL remain FULL.
REQ-019 window_valid SHALL be high exactly when the state is FULL.
REQ-020 An update_pending flag SHALL be set on the edge that accepts a sample leaving the state FULL, including the third sample that enters FULL.
REQ-021 On the edge after update_pending is set, filtered_out SHALL capture median_in and filtered_valid SHALL be high for that cycle only.
REQ-022 Latency SHALL be as follows: sample accepted at edge N, taps valid after edge N, filtered_out/filtered_valid valid after edge N+1.
REQ-023 Back-to-back samples on consecutive cycles SHALL each produce one filtered_valid pulse with none lost.
REQ-024 flush SHALL set the state to EMPTY, clear the taps to 0, and clear update_pending, with filtered_out retaining its value.
REQ-025 When flush and sample_valid are high together, the flush SHALL apply first and the sample SHALL load as the first entry: state ONE, tap0=sample_in, tap1=tap2=0.
REQ-026 An idle counter SHALL reset to 0 on every accepted sample and on flush, and SHALL increment otherwise while the state is not EMPTY.
REQ-027 When the idle counter reaches TIMEOUT_CYCLES-1 without a sample, the block SHALL perform a flush identical to REQ-024 and pulse stale for one cycle.
REQ-028 If a sample arrives on the timeout cycle, the sample SHALL win: no stale pulse, counter cleared, normal shift.
REQ-029 In the EMPTY state the idle counter SHALL hold at 0, and stale SHALL never fire.
REQ-030 The block SHALL perform no arithmetic on samples, and the full WIDTH SHALL be carried unmodified.

Reset
REQ-031 Asserting reset_n low SHALL asynchronously force all of the following to 0: taps, filtered_out, filtered_valid, stale, window_valid, fill_level (EMPTY), update_pending and the idle counter.
REQ-032 Reset asserted mid-operation SHALL discard all samples and any pending filtered update.
REQ-033 Release of reset SHALL be synchronous to clk, and the first sample SHALL be accepted no earlier than the first rising edge after release.

Verification
REQ-034 Fill test: samples 100, 300, 200 -> fill_level 1, 2, 3; window_valid rises after the third; one cycle later filtered_out=200 with one filtered_valid pulse.
REQ-035 Streaming test: after fill, a fourth sample of 50 on the next cycle -> taps 50/200/300; filtered_valid pulses on two consecutive cycles with values 200, then 200.
REQ-036 Flush collision test: FULL, then flush with sample_valid and sample_in=7 -> fill_level 1, tap0=7, taps 1-2 = 0, no filtered_valid.
REQ-037 Timeout test: with TIMEOUT_CYCLES=8 and state TWO, no samples -> stale pulses on the 8th idle cycle, fill_level 0; no stale thereafter.
REQ-038 Timeout race test: a sample arriving exactly on the timeout cycle -> no stale pulse, state advances, idle counter 0.
REQ-039 Reset test: reset_n pulsed low between a third sample and its filtered_valid -> no filtered_valid; all outputs 0 immediately.
